// File: rtl/hier_resp_pkg.sv
// Shared types and constants for the hierarchical response collector.
// Holds the default tree fan-out, payload width and the counter ceiling.
package hier_resp_pkg;

    localparam int DEF_NUM_CHILD = 5;
    localparam int DEF_DATA_W    = 16;
    localparam int DEF_IDX_W     = $clog2(DEF_NUM_CHILD);

    localparam logic [15:0] STAT_MAX = 16'hFFFF;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] data;
        logic [DEF_IDX_W-1:0]  idx;
        logic                  last;
    } resp_beat_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        return (value == STAT_MAX) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/hier_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, wrapping
// from NUM_CHILD-1 back to 0. Produces a one-hot grant and its encoded index.
module hier_rr_arbiter
    import hier_resp_pkg::*;
#(
    parameter int  NUM_CHILD = DEF_NUM_CHILD,
    localparam int IDX_W     = $clog2(NUM_CHILD)
) (
    input  logic [NUM_CHILD-1:0] req,
    input  logic [IDX_W-1:0]     ptr,
    input  logic                 en,
    output logic [NUM_CHILD-1:0] gnt,
    output logic [IDX_W-1:0]     gnt_idx
);

    localparam logic [IDX_W:0] N_W = (IDX_W+1)'(NUM_CHILD);

    logic [IDX_W:0] cand;
    logic           found;

    // One extra bit on the candidate lets ptr+k exceed NUM_CHILD before folding back.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = '0;
        for (int k = 0; k < NUM_CHILD; k++) begin
            cand = {1'b0, ptr} + (IDX_W+1)'(k);
            if (cand >= N_W) begin
                cand = cand - N_W;
            end
            if (en && !found && req[cand[IDX_W-1:0]]) begin
                found                 = 1'b1;
                gnt[cand[IDX_W-1:0]]  = 1'b1;
                gnt_idx               = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/hier_resp_collector.sv
// Collects one response per child per round and serialises them onto a registered
// parent channel. Optional counters are enabled by HIER_RESP_COLLECT_STATS_EN.
module hier_resp_collector
    import hier_resp_pkg::*;
#(
    parameter int  NUM_CHILD = DEF_NUM_CHILD,
    parameter int  DATA_W    = DEF_DATA_W,
    localparam int IDX_W     = $clog2(NUM_CHILD)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CHILD-1:0]        child_valid,
    output logic [NUM_CHILD-1:0]        child_ready,
    input  logic [NUM_CHILD*DATA_W-1:0] child_data,
    output logic                        up_valid,
    input  logic                        up_ready,
    output logic [DATA_W-1:0]           up_data,
    output logic [IDX_W-1:0]            up_idx,
    output logic                        up_last,
    output logic                        round_busy
`ifdef HIER_RESP_COLLECT_STATS_EN
    ,
    output logic [15:0]                 rounds_done,
    output logic [15:0]                 stall_cycles
`endif
);

    logic                 up_valid_q, up_valid_d;
    logic [DATA_W-1:0]    up_data_q, up_data_d;
    logic [IDX_W-1:0]     up_idx_q, up_idx_d;
    logic                 up_last_q, up_last_d;
    logic [NUM_CHILD-1:0] done_mask_q, done_mask_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;

    logic                 can_load;
    logic                 arb_en;
    logic                 gnt_any;
    logic                 close_round;
    logic [NUM_CHILD-1:0] elig;
    logic [NUM_CHILD-1:0] gnt;
    logic [NUM_CHILD-1:0] mask_set;
    logic [IDX_W-1:0]     gnt_idx;
    logic [DATA_W-1:0]    sel_data;

    // Gating on rst_n keeps every child_ready low while the block is held in reset.
    assign can_load = !up_valid_q || up_ready;
    assign arb_en   = can_load && rst_n;
    assign elig     = child_valid & ~done_mask_q;

    hier_rr_arbiter #(
        .NUM_CHILD (NUM_CHILD)
    ) u_arb (
        .req     (elig),
        .ptr     (rr_ptr_q),
        .en      (arb_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign gnt_any     = |gnt;
    assign child_ready = gnt;
    assign mask_set    = done_mask_q | gnt;
    assign close_round = gnt_any && (&mask_set);

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_CHILD; i++) begin
            if (gnt[i]) begin
                sel_data = sel_data | child_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        up_valid_d  = up_valid_q && !up_ready;
        up_data_d   = up_data_q;
        up_idx_d    = up_idx_q;
        up_last_d   = up_last_q;
        done_mask_d = done_mask_q;
        rr_ptr_d    = rr_ptr_q;
        if (gnt_any) begin
            up_valid_d  = 1'b1;
            up_data_d   = sel_data;
            up_idx_d    = gnt_idx;
            up_last_d   = close_round;
            done_mask_d = close_round ? '0 : mask_set;
            rr_ptr_d    = (gnt_idx == IDX_W'(NUM_CHILD-1)) ? '0 : gnt_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            up_valid_q  <= 1'b0;
            up_data_q   <= '0;
            up_idx_q    <= '0;
            up_last_q   <= 1'b0;
            done_mask_q <= '0;
            rr_ptr_q    <= '0;
        end else begin
            up_valid_q  <= up_valid_d;
            up_data_q   <= up_data_d;
            up_idx_q    <= up_idx_d;
            up_last_q   <= up_last_d;
            done_mask_q <= done_mask_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign up_valid   = up_valid_q;
    assign up_data    = up_data_q;
    assign up_idx     = up_idx_q;
    assign up_last    = up_last_q;
    assign round_busy = |done_mask_q;

`ifdef HIER_RESP_COLLECT_STATS_EN
    logic [15:0] rounds_done_q, rounds_done_d;
    logic [15:0] stall_cycles_q, stall_cycles_d;

    always_comb begin
        rounds_done_d  = close_round ? sat_inc(rounds_done_q) : rounds_done_q;
        stall_cycles_d = (up_valid_q && !up_ready) ? sat_inc(stall_cycles_q) : stall_cycles_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rounds_done_q  <= '0;
            stall_cycles_q <= '0;
        end else begin
            rounds_done_q  <= rounds_done_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign rounds_done  = rounds_done_q;
    assign stall_cycles = stall_cycles_q;
`endif

endmodule
